// File: rtl/hs32_timer_pkg.sv
// Shared definitions for the hs32 timer and its bus controller: register
// indices, register bit positions and the timer configuration encodings.
package hs32_timer_pkg;

    localparam logic [1:0] TCTRL  = 2'd0;
    localparam logic [1:0] TMATCH = 2'd1;
    localparam logic [1:0] TSTAT  = 2'd2;
    localparam logic [1:0] TCMD   = 2'd3;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_CLKSRC_LSB = 1;
    localparam int CLKSRC_W        = 3;
    localparam int CTRL_TMODE_LSB  = 4;
    localparam int TMODE_W         = 2;
    localparam int CTRL_OMODE_LSB  = 6;
    localparam int OMODE_W         = 2;
    localparam int CTRL_IE         = 8;
    localparam int CTRL_SHADOW     = 9;
    localparam int CTRL_W          = 10;

    localparam int STAT_MF   = 0;
    localparam int STAT_OVR  = 1;
    localparam int STAT_PEND = 2;

    localparam int CMD_RESTART = 0;
    localparam int CMD_LOAD    = 1;

    typedef enum logic [CLKSRC_W-1:0] {
        CLK_SYS     = 3'd0,
        CLK_DIV8    = 3'd1,
        CLK_DIV64   = 3'd2,
        CLK_DIV256  = 3'd3,
        CLK_DIV1024 = 3'd4
    } clk_src_e;

    typedef enum logic [TMODE_W-1:0] {
        TMODE_ONESHOT  = 2'd0,
        TMODE_PERIODIC = 2'd1,
        TMODE_FREERUN  = 2'd2,
        TMODE_RSVD     = 2'd3
    } timer_mode_e;

    typedef enum logic [OMODE_W-1:0] {
        OMODE_NONE   = 2'd0,
        OMODE_TOGGLE = 2'd1,
        OMODE_SET    = 2'd2,
        OMODE_CLEAR  = 2'd3
    } output_mode_e;

endpackage

// File: rtl/hs32_timer_ctrl.sv
// Bus-mapped controller for one hs32_timer: config/match registers, timer
// reset and restart sequencing, and sticky maskable match interrupt.
module hs32_timer_ctrl
    import hs32_timer_pkg::*;
#(
    parameter logic [31:0] MATCH_RESET    = 32'hFFFF_FFFF,
    parameter int unsigned RESTART_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stb,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         dtw,
    output logic [31:0]         dtr,
    output logic                ack,
    output logic                timer_reset,
    output logic [CLKSRC_W-1:0] clk_source,
    output logic [TMODE_W-1:0]  timer_mode,
    output logic [OMODE_W-1:0]  output_mode,
    output logic [31:0]         match,
    input  logic                int_match,
    output logic                irq
);

    localparam logic [3:0] RESTART_LOAD = 4'(RESTART_CYCLES);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       match_buf_q, match_buf_d, match_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mf_q, mf_d, ovr_q, ovr_d, pend_q, pend_d;
    logic              int_q;
    logic              timer_reset_d;
    logic [31:0]       rd_data;

    logic xfer, wr, rd, wr_ctrl, wr_match, wr_stat, wr_cmd;
    logic en, shadow, match_evt, restart_cmd, load_cmd, load_evt;

    // A request is taken only when no ack is outstanding, giving the 1-cycle
    // latency and the one-transfer-per-two-cycles ceiling.
    assign xfer     = stb & ~ack;
    assign wr       = xfer & we;
    assign rd       = xfer & ~we;
    assign wr_ctrl  = wr & (addr == TCTRL);
    assign wr_match = wr & (addr == TMATCH);
    assign wr_stat  = wr & (addr == TSTAT);
    assign wr_cmd   = wr & (addr == TCMD);

    assign en          = ctrl_q[CTRL_EN];
    assign shadow      = ctrl_q[CTRL_SHADOW];
    assign restart_cmd = wr_cmd & dtw[CMD_RESTART] & en;
    assign load_cmd    = wr_cmd & dtw[CMD_LOAD];
    assign match_evt   = int_match & ~int_q & ~timer_reset;
    assign load_evt    = match_evt | ~en | load_cmd;

    always_comb begin
        ctrl_d      = wr_ctrl ? dtw[CTRL_W-1:0] : ctrl_q;
        match_buf_d = wr_match ? dtw : match_buf_q;
        match_d     = match;
        pend_d      = pend_q;

        if (!ctrl_d[CTRL_EN])
            cnt_d = 4'd0;
        else if (restart_cmd)
            cnt_d = RESTART_LOAD;
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
        else
            cnt_d = cnt_q;
        timer_reset_d = ~ctrl_d[CTRL_EN] | (cnt_d != 4'd0);

        // Event set takes priority over a same-cycle write-1-to-clear.
        mf_d  = match_evt ? 1'b1 : ((wr_stat & dtw[STAT_MF]) ? 1'b0 : mf_q);
        ovr_d = (match_evt & mf_q) ? 1'b1 : ((wr_stat & dtw[STAT_OVR]) ? 1'b0 : ovr_q);

        if (wr_match && !shadow) begin
            match_d = dtw;
            pend_d  = 1'b0;
        end else if (shadow && (pend_q || wr_match) && load_evt) begin
            match_d = match_buf_d;
            pend_d  = 1'b0;
        end else if (wr_match) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            TCTRL:   rd_data = {{(32-CTRL_W){1'b0}}, ctrl_q};
            TMATCH:  rd_data = match_buf_q;
            TSTAT:   rd_data = {29'd0, pend_q, ovr_q, mf_q};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= '0;
            match_buf_q <= MATCH_RESET;
            match       <= MATCH_RESET;
            cnt_q       <= 4'd0;
            mf_q        <= 1'b0;
            ovr_q       <= 1'b0;
            pend_q      <= 1'b0;
            int_q       <= 1'b0;
            timer_reset <= 1'b1;
            ack         <= 1'b0;
            dtr         <= 32'd0;
            irq         <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            match_buf_q <= match_buf_d;
            match       <= match_d;
            cnt_q       <= cnt_d;
            mf_q        <= mf_d;
            ovr_q       <= ovr_d;
            pend_q      <= pend_d;
            int_q       <= int_match;
            timer_reset <= timer_reset_d;
            ack         <= xfer;
            dtr         <= rd ? rd_data : 32'd0;
            irq         <= ctrl_q[CTRL_IE] & mf_q;
        end
    end

    assign clk_source  = ctrl_q[CTRL_CLKSRC_LSB +: CLKSRC_W];
    assign timer_mode  = ctrl_q[CTRL_TMODE_LSB +: TMODE_W];
    assign output_mode = ctrl_q[CTRL_OMODE_LSB +: OMODE_W];

endmodule
